// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand and result handshake bundle for alu_pipe.
// master = operand producer / result consumer, slave = the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OPERATIONCODE;
    logic [WIDTH-1:0] O;
    logic             zero;
    logic             carry;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, A, B, OPERATIONCODE, out_ready,
        input  in_ready, O, zero, carry, out_valid
    );

    modport slave (
        input  in_valid, A, B, OPERATIONCODE, out_ready,
        output in_ready, O, zero, carry, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit ALU with valid/ready on operands and result, one op in flight.
// Single-cycle ops finish one edge after accept; MUL is a shift-add iterative
// multiply that exists only when ALU_MUL_EN is defined. Without ALU_MUL_EN,
// opcode 010 completes in one cycle with O=0 and carry=1 marking it unsupported.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam logic [1:0] StIdle = 2'd0;
`ifdef ALU_MUL_EN
    localparam logic [1:0] StBusy = 2'd1;
`endif
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpSlt = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpXor = 3'b110;
    localparam logic [2:0] OpNor = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

`ifdef ALU_MUL_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    assign in_ready      = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.O         = o_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = (state_q == StDone);

`ifdef ALU_MUL_EN
    assign mul_start = accept && (bus.OPERATIONCODE == OpMul);
`else
    assign mul_start = 1'b0;
`endif

    // Single-cycle result and carry for the opcode currently presented.
    always_comb begin
        sum_w     = {1'b0, bus.A} + {1'b0, bus.B};
        diff_w    = {1'b0, bus.A} - {1'b0, bus.B};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (bus.OPERATIONCODE)
            OpAdd: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
            end
            OpSub: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
            end
            // Only reaches the result register when the multiplier is not built.
            OpMul: begin
                alu_res   = '0;
                alu_carry = 1'b1;
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OpAnd: alu_res = bus.A & bus.B;
            OpOr:  alu_res = bus.A | bus.B;
            OpXor: alu_res = bus.A ^ bus.B;
            OpNor: alu_res = ~(bus.A | bus.B);
            default: alu_res = '0;
        endcase
    end

    // Next state: consume, multiply iteration, and accept (accept overrides consume).
    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef ALU_MUL_EN
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ALU_MUL_EN
            StBusy: begin
                // WIDTH iterations, then one more edge to publish the product.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = StDone;
                    o_d     = acc_q[WIDTH-1:0];
                    carry_d = |acc_q[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_q[WIDTH-1:0] == '0);
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: ;
        endcase

`ifdef ALU_MUL_EN
        if (mul_start) begin
            state_d  = StBusy;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
        end
`endif
        if (accept && !mul_start) begin
            state_d = StDone;
            o_d     = alu_res;
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            o_q      <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`ifdef ALU_MUL_EN
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`ifdef ALU_MUL_EN
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized scoreboard bench for alu_pipe (WIDTH=32).
// Honors ALU_MUL_EN the same way the design does.
module tb_alu_pipe;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] o;
        logic         z;
        logic         c;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    bit   seen = 1'b0;
    bit   rnd_ready = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the opcode rules.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.lat = 1;
        e.c = 1'b0;
        e.o = '0;
        e.acc_cyc = 0;
        p = '0;
        case (op)
            3'd0: begin
                p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                e.o = p[W-1:0];
                e.c = p[W];
            end
            3'd1: begin
                e.o = a - b;
                e.c = (a < b);
            end
            3'd2: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.o = p[W-1:0];
                e.c = (p[2*W-1:W] != '0);
                e.lat = W + 1;
`else
                e.o = '0;
                e.c = 1'b1;
`endif
            end
            3'd3: e.o = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd4: e.o = a & b;
            3'd5: e.o = a | b;
            3'd6: e.o = a ^ b;
            default: e.o = ~(a | b);
        endcase
        e.z = (e.o == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got O=%0h with nothing pending", bus.O);
            end else begin
                chk("result{O,zero,carry}", 64'({bus.O, bus.zero, bus.carry}),
                    64'({sb[0].o, sb[0].z, sb[0].c}));
                if (!seen) begin
                    chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.OPERATIONCODE = op;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = model(op, a, b);
                e.acc_cyc = cyc;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 500) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.OPERATIONCODE = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) timeout("drain");
    endtask

    function automatic logic [W-1:0] pick();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] op;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.OPERATIONCODE = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset O", 64'(bus.O), 64'd0);
        chk("reset zero", 64'(bus.zero), 64'd0);
        chk("reset carry", 64'(bus.carry), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors.
        send(3'b100, 32'hFF5B_0E44, 32'h648E_37A6);
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        send(3'b001, 32'd3, 32'd5);
        send(3'b011, 32'h8000_0000, 32'd1);
        send(3'b011, 32'd1, 32'h8000_0000);
        send(3'b111, 32'd0, 32'd0);
        send(3'b010, 32'd7, 32'd6);
`ifdef ALU_MUL_EN
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("busy in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
`endif
        drain();
        send(3'b010, 32'h0001_0000, 32'h0001_0000);
        drain();

        // Backpressure then back-to-back accept on consume.
        bus.out_ready = 1'b0;
        send(3'b101, 32'h1234_0000, 32'h0000_5678);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) timeout("or_result");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00);
        drain();

        // Reset in the middle of an operation.
`ifdef ALU_MUL_EN
        op = 3'b010;
        bus.out_ready = 1'b1;
`else
        op = 3'b101;
        bus.out_ready = 1'b0;
`endif
        send(op, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post-reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("post-reset O", 64'(bus.O), 64'd0);
        chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(3'b000, 32'd2, 32'd2);
        drain();

        // Randomized traffic with random consumer stalls.
        rnd_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            send(3'($urandom_range(0, 7)), pick(), pick());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
